multi_port_reg_file: RTL and testbench
======================================

# multi_port_reg_file

- Parametrised successor of the single-cycle CPU register file.
- Provides NUM_RD combinational read ports and NUM_WR clocked write ports over REG_NUM entries of DATA_WIDTH bits.
- Adds an optional hardwired-zero register 0, deterministic write-port priority, and a write-collision flag.
- After reset, a sequencer zero-clears the storage one entry per cycle and reports `busy`.
- Sits in the decode/writeback stages of both the single-cycle and upcoming superscalar cores.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per register
- REG_NUM, 32, number of registers (≥2)
- NUM_RD, 2, read port count (≥1)
- NUM_WR, 1, write port count (≥1)
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes
- AW (localparam), $clog2(REG_NUM), register-number width

Ports (port k occupies slice [k*W +: W] of each flattened vector):
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- busy  out  1  1 while the clear sequence runs
- rdNum  in  NUM_RD*AW  read register numbers
- rdData  out  NUM_RD*DATA_WIDTH  read data
- wrEnable  in  NUM_WR  per-port write enable
- wrNum  in  NUM_WR*AW  write register numbers
- wrData  in  NUM_WR*DATA_WIDTH  write data
- wrCollision  out  1  registered flag: the previous cycle had ≥2 enabled write ports targeting the same register

## Operation
- FSM states: CLEAR, READY.
- rst high at a posedge: state←CLEAR, clrCnt←0, wrCollision←0. No entry is cleared while rst is high.
- CLEAR with rst low, each posedge:
  - storage[clrCnt]←0.
  - If clrCnt==REG_NUM-1: state←READY.
  - Otherwise clrCnt←clrCnt+1.
- rst asserted mid-CLEAR: the sequence restarts from entry 0.
- rst asserted in READY: CLEAR is re-entered. Storage is not reset directly; the sequencer clears it.
- `busy` = (state==CLEAR).
- Write ports (READY only):
  - Each posedge with rst low, every port k with wrEnable[k]=1 writes wrData[k] to storage[wrNum[k]].
  - If ports collide on one register, the highest-index enabled port wins.
- Writes are ignored in the following cases:
  - state is CLEAR;
  - rst is high;
  - ZERO_REG=1 and wrNum[k]==0.
- wrCollision:
  - Updated every posedge with rst low, in either state.
  - Set to 1 if any two enabled ports had equal wrNum that cycle, else 0.
  - A zero-register target counts as a collision.
- Reads (combinational):
  - rdData[j] = storage[rdNum[j]].
  - Forced to 0 while busy=1.
  - Forced to 0 when ZERO_REG=1 and rdNum[j]==0.
- rdNum ≥ REG_NUM (non-power-of-two REG_NUM): reads return 0; writes are ignored.

## Timing
- Output values during and after reset:
  - busy=1 from the first posedge with rst high.
  - wrCollision=0.
  - rdData=0 while busy.
- Clear latency: busy falls after the REG_NUM-th posedge with rst low following reset.
- Write-to-read latency: one cycle. A value written at edge E is visible on rdData combinationally after E.
- Same-cycle read of a register being written: behaviour is fixed by the macro in Configuration.
- wrCollision: one cycle after the colliding cycle, held for one cycle unless the collision repeats.
- No handshake on ports. The client must not issue writes while busy=1; such writes are dropped silently.

## Configuration
- Macro: `REG_FILE_BYPASS_EN`
- Defined:
  - A read whose rdNum matches an enabled, non-ignored write port in the same cycle returns that port's wrData combinationally.
  - If several ports match, the highest-index port's wrData is returned.
  - Zero-register and busy forcing still take precedence.
- Undefined: reads return the pre-edge storage value; the new value appears after the edge.

## Test plan
- **Reset/clear:** REG_NUM=32.
  - rst high 2 cycles, then low → busy=1 for exactly 32 cycles after rst falls, then 0.
  - All 32 registers read 0.
  - A write of 0x1234 to r5 during busy is dropped; r5 still reads 0 afterwards.
- **Basic write/read:**
  - Write 0xDEADBEEF to r7 → next cycle rdData[0]=0xDEADBEEF with rdNum[0]=7.
  - rdData[1] with rdNum[1]=7 equals the same value.
- **Zero register:**
  - ZERO_REG=1: write 0xFFFFFFFF to r0 → r0 reads 0.
  - ZERO_REG=0: same write → r0 reads 0xFFFFFFFF.
- **Collision:**
  - NUM_WR=2: port0 writes 0x1 to r3, port1 writes 0x2 to r3 in the same cycle.
  - r3 then reads 0x2, and wrCollision=1 for exactly one cycle.
- **Bypass:**
  - Write 0xA5 to r9 while rdNum[0]=9 (r9 previously 0x11).
  - With the macro: rdData[0]=0xA5 in the same cycle.
  - Without the macro: 0x11, then 0xA5 after the edge.
- **Reset mid-clear:**
  - Assert rst at clear cycle 10 with r0–r9 already cleared.
  - busy stays 1 for a full 32 cycles after the second deassertion.
  - Registers written before reset read 0 afterwards.

Source files
------------

// File: rtl/multi_port_reg_file.sv
// Parametrised multi-port register file with post-reset clear sequencer.
// Optional same-cycle write-to-read bypass is enabled by defining REG_FILE_BYPASS_EN.
module multi_port_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           busy,
    input  logic [NUM_RD*$clog2(REG_NUM)-1:0] rdNum,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rdData,
    input  logic [NUM_WR-1:0]              wrEnable,
    input  logic [NUM_WR*$clog2(REG_NUM)-1:0] wrNum,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   wrData,
    output logic                           wrCollision
);

    localparam int AW = $clog2(REG_NUM);
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;
    localparam logic [AW:0] REG_NUM_W = (AW+1)'(REG_NUM);
    localparam logic [AW-1:0] LAST_IDX = AW'(REG_NUM - 1);

    logic [0:0]            state_r;
    logic [AW-1:0]         clrCnt_r;
    logic [DATA_WIDTH-1:0] storage_r [REG_NUM];
    logic                  wrCollision_r;
    logic [NUM_WR-1:0]     wrValid_s;
    logic                  collision_s;
    logic [AW-1:0]         rdIdx_s;
    logic [DATA_WIDTH-1:0] rdVal_s;

    // Register numbers beyond REG_NUM only exist when REG_NUM is not a power of two.
    function automatic logic inRange(input logic [AW-1:0] num);
        return ({1'b0, num} < REG_NUM_W);
    endfunction

    function automatic logic isZeroReg(input logic [AW-1:0] num);
        return (ZERO_REG != 0) && (num == {AW{1'b0}});
    endfunction

    assign busy        = (state_r == CLEAR);
    assign wrCollision = wrCollision_r;

    // Qualify each write port: only READY, out of reset, legal and non-zero target.
    always_comb begin
        wrValid_s = {NUM_WR{1'b0}};
        for (int k = 0; k < NUM_WR; k++) begin
            if (wrEnable[k] && (state_r == READY) && !rst &&
                inRange(wrNum[k*AW +: AW]) && !isZeroReg(wrNum[k*AW +: AW])) begin
                wrValid_s[k] = 1'b1;
            end else begin
                wrValid_s[k] = 1'b0;
            end
        end
    end

    // Detect two enabled ports aiming at the same register (zero register included).
    always_comb begin
        collision_s = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wrEnable[i] && wrEnable[j] && (wrNum[i*AW +: AW] == wrNum[j*AW +: AW])) begin
                    collision_s = 1'b1;
                end else begin
                    collision_s = collision_s;
                end
            end
        end
    end

    // Sequencer, storage writes and collision flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= CLEAR;
            clrCnt_r      <= {AW{1'b0}};
            wrCollision_r <= 1'b0;
        end else begin
            wrCollision_r <= collision_s;
            case (state_r)
                CLEAR: begin
                    storage_r[clrCnt_r] <= {DATA_WIDTH{1'b0}};
                    if (clrCnt_r == LAST_IDX) begin
                        state_r <= READY;
                    end else begin
                        clrCnt_r <= clrCnt_r + AW'(1);
                    end
                end
                READY: begin
                    // Later iterations override earlier ones, so the highest port wins.
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (wrValid_s[k]) begin
                            storage_r[wrNum[k*AW +: AW]] <= wrData[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                default: begin
                    state_r <= CLEAR;
                end
            endcase
        end
    end

    // Combinational read ports with busy / zero-register / range forcing.
    always_comb begin
        rdData  = {(NUM_RD*DATA_WIDTH){1'b0}};
        rdIdx_s = {AW{1'b0}};
        rdVal_s = {DATA_WIDTH{1'b0}};
        for (int j = 0; j < NUM_RD; j++) begin
            rdIdx_s = rdNum[j*AW +: AW];
            rdVal_s = storage_r[rdIdx_s];
`ifdef REG_FILE_BYPASS_EN
            for (int k = 0; k < NUM_WR; k++) begin
                if (wrValid_s[k] && (wrNum[k*AW +: AW] == rdIdx_s)) begin
                    rdVal_s = wrData[k*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    rdVal_s = rdVal_s;
                end
            end
`endif
            if (busy || !inRange(rdIdx_s) || isZeroReg(rdIdx_s)) begin
                rdData[j*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end else begin
                rdData[j*DATA_WIDTH +: DATA_WIDTH] = rdVal_s;
            end
        end
    end

endmodule

// File: tb/tb_multi_port_reg_file.sv
// Directed bench for multi_port_reg_file: one instance with ZERO_REG=1, one with ZERO_REG=0,
// sharing all inputs. Expectations follow REG_FILE_BYPASS_EN when it is defined.
module tb_multi_port_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy, busyNz;
    logic [9:0]  rdNum;
    logic [63:0] rdData, rdDataNz;
    logic [1:0]  wrEnable;
    logic [9:0]  wrNum;
    logic [63:0] wrData;
    logic        wrCollision, wrCollisionNz;
    int          totalCnt = 0;
    int          badCnt = 0;

`ifdef REG_FILE_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'h0000_00A5;
`else
    localparam logic [31:0] BYP_EXP = 32'h0000_0011;
`endif

    always #5 clk = ~clk;

    multi_port_reg_file #(.DATA_WIDTH(32), .REG_NUM(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .busy(busy), .rdNum(rdNum), .rdData(rdData),
        .wrEnable(wrEnable), .wrNum(wrNum), .wrData(wrData), .wrCollision(wrCollision)
    );

    multi_port_reg_file #(.DATA_WIDTH(32), .REG_NUM(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) u_dutNz (
        .clk(clk), .rst(rst), .busy(busyNz), .rdNum(rdNum), .rdData(rdDataNz),
        .wrEnable(wrEnable), .wrNum(wrNum), .wrData(wrData), .wrCollision(wrCollisionNz)
    );

    task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setWr(input int p, input logic [4:0] n, input logic [31:0] d);
        wrEnable[p]      = 1'b1;
        wrNum[p*5 +: 5]  = n;
        wrData[p*32 +: 32] = d;
    endtask

    task automatic setRd(input logic [4:0] a, input logic [4:0] b);
        rdNum = {b, a};
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; wrEnable = 2'b00; wrNum = '0; wrData = '0; rdNum = '0;
        tick();
        tick();
        chkVal("rstBusy", 32'(busy), 32'd1);
        chkVal("rstColl", 32'(wrCollision), 32'd0);
        chkVal("rstRd0", rdData[31:0], 32'h0);

        // Clear sequence, with writes attempted while busy
        rst = 1'b0;
        n = 0;
        do begin
            if (n == 3) begin
                setWr(0, 5'd5, 32'h0000_1234);
                setWr(1, 5'd1, 32'h0000_4321);
            end
            if (n == 30) wrEnable = 2'b00;
            tick();
            n++;
        end while (busy && n < 100);
        wrEnable = 2'b00;
        chkVal("clearLen", 32'(n), 32'd32);
        setRd(5'd5, 5'd1);
        chkVal("dropR5", rdData[31:0], 32'h0);
        chkVal("dropR1", rdData[63:32], 32'h0);
        for (int i = 0; i < 32; i++) begin
            setRd(5'(i), 5'(31 - i));
            if (rdData[31:0] !== 32'h0 || rdDataNz[63:32] !== 32'h0)
                chkVal($sformatf("clr%0d", i), rdData[31:0] | rdDataNz[63:32], 32'h0);
        end
        chkVal("clearAllNz", rdDataNz[31:0], 32'h0);

        // Basic write/read
        setWr(0, 5'd7, 32'hDEAD_BEEF);
        tick();
        wrEnable = 2'b00;
        setRd(5'd7, 5'd7);
        chkVal("r7Port0", rdData[31:0], 32'hDEAD_BEEF);
        chkVal("r7Port1", rdData[63:32], 32'hDEAD_BEEF);
        chkVal("noColl", 32'(wrCollision), 32'd0);

        // Zero register
        setWr(0, 5'd0, 32'hFFFF_FFFF);
        tick();
        wrEnable = 2'b00;
        setRd(5'd0, 5'd7);
        chkVal("zeroReg", rdData[31:0], 32'h0);
        chkVal("noZeroReg", rdDataNz[31:0], 32'hFFFF_FFFF);

        // Collision and port priority
        setWr(0, 5'd3, 32'h1);
        setWr(1, 5'd3, 32'h2);
        tick();
        wrEnable = 2'b00;
        setRd(5'd3, 5'd3);
        chkVal("collData", rdData[31:0], 32'h2);
        chkVal("collFlag", 32'(wrCollision), 32'd1);
        tick();
        chkVal("collClear", 32'(wrCollision), 32'd0);
        setWr(0, 5'd0, 32'h7);
        setWr(1, 5'd0, 32'h8);
        tick();
        wrEnable = 2'b00;
        chkVal("collZero", 32'(wrCollision), 32'd1);
        setRd(5'd0, 5'd3);
        chkVal("collZeroNz", rdDataNz[31:0], 32'h8);

        // Same-cycle bypass behaviour
        setWr(0, 5'd9, 32'h11);
        tick();
        setWr(0, 5'd9, 32'hA5);
        setRd(5'd9, 5'd3);
        chkVal("bypassSame", rdData[31:0], BYP_EXP);
        tick();
        wrEnable = 2'b00;
        #1;
        chkVal("bypassAfter", rdData[31:0], 32'hA5);

        // Reset in the middle of the clear sequence
        setWr(0, 5'd12, 32'h55);
        tick();
        wrEnable = 2'b00;
        rst = 1'b1;
        tick();
        chkVal("rst2Busy", 32'(busy), 32'd1);
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 2) begin
                setRd(5'd12, 5'd7);
                chkVal("busyForce", rdData[31:0], 32'h0);
            end
        end while (busy && n < 100);
        chkVal("clearLen2", 32'(n), 32'd32);
        setRd(5'd7, 5'd12);
        chkVal("r7Cleared", rdData[31:0], 32'h0);
        chkVal("r12Cleared", rdData[63:32], 32'h0);
        setRd(5'd9, 5'd0);
        chkVal("r9Cleared", rdData[31:0], 32'h0);
        chkVal("r0ClearedNz", rdDataNz[63:32], 32'h0);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
